// File: rtl/bus_pkg.sv
// ============================================================================
// bus_pkg : shared widths, FSM state type and default region map for bus_fabric
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_RDATA           = 32'h0;
  localparam logic [7:0]        DEFAULT_REGION_MASK = 8'b0001_0111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/bus_fabric_if.sv
// ============================================================================
// bus_fabric_if : CPU-side enable/wstrb/addr/wvalue/rvalue bus with stall/err
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface bus_fabric_if;
  import bus_pkg::*;

  logic              enable;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wvalue;
  logic [DATA_W-1:0] rvalue;
  logic              stall;
  logic              err;

  modport master (output enable, wstrb, addr, wvalue, input rvalue, stall, err);
  modport slave  (input enable, wstrb, addr, wvalue, output rvalue, stall, err);

endinterface

`default_nettype wire

// File: rtl/bus_watchdog.sv
// ============================================================================
// bus_watchdog : counts stalled cycles, flags expiry on the TIMEOUT_CYCLES-th
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expiry fires during the last allowed stall cycle so completion lands next cycle.
  assign expire_o = inc_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_fabric.sv
// ============================================================================
// bus_fabric : single-master interconnect with registered region select,
//              wait states, unmapped-region errors and sticky fault address.
//              Optional watchdog: define BUS_FABRIC_TIMEOUT_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_fabric
  import bus_pkg::*;
#(
  parameter int                  SEL_BITS       = 3,
  parameter int                  N_SLAVES       = 2**SEL_BITS,
  parameter logic [N_SLAVES-1:0] REGION_MASK    = N_SLAVES'(DEFAULT_REGION_MASK),
  parameter int                  TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  bus_fabric_if.slave                m,
  output logic [N_SLAVES-1:0]        s_enable_o,
  output logic [3:0]                 s_wstrb_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_wvalue_o,
  input  logic [DATA_W*N_SLAVES-1:0] s_rvalue_i,
  input  logic [N_SLAVES-1:0]        s_ready_i,
  input  logic                       fault_clr_i,
  output logic                       fault_valid_o,
  output logic [ADDR_W-1:0]          fault_addr_o
);

  if (N_SLAVES != 2**SEL_BITS || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_fabric: N_SLAVES must equal 2**SEL_BITS and TIMEOUT_CYCLES must be >= 1");
  end

  bus_state_e          state_q, state_d;
  logic [SEL_BITS-1:0] sel_q, sel_d, region;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic                fault_valid_q, fault_valid_d;
  logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d, fault_src;
  logic                fault_evt, stall, accept, mapped, strobe;
  logic [DATA_W-1:0]   sel_rdata;

  assign region = m.addr[ADDR_W-1 -: SEL_BITS];
  assign mapped = REGION_MASK[region];
  assign stall  = (pend_q || state_q == WAIT) && !s_ready_i[sel_q];
  assign accept = (state_q == IDLE) && !stall;
  assign strobe = accept && m.enable && mapped;

  assign s_enable_o = strobe ? (N_SLAVES'(1) << region) : '0;
  assign s_wstrb_o  = m.wstrb;
  assign s_addr_o   = m.addr;
  assign s_wvalue_o = m.wvalue;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_BITS'(i)) sel_rdata = s_rvalue_i[DATA_W*i +: DATA_W];
    end
  end

  // An error completion always returns ERR_RDATA, even if sel_q points at a live slave.
  assign m.rvalue      = (err_q || !REGION_MASK[sel_q]) ? ERR_RDATA : sel_rdata;
  assign m.stall       = stall;
  assign m.err         = err_q;
  assign fault_valid_o = fault_valid_q;
  assign fault_addr_o  = fault_addr_q;

`ifdef BUS_FABRIC_TIMEOUT_EN
  logic              wd_expire;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;

  assign acc_addr_d = strobe ? m.addr : acc_addr_q;

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .inc_i    (stall),
    .clr_i    (!stall),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_addr_q <= '0;
    end else begin
      acc_addr_q <= acc_addr_d;
    end
  end
`endif

  always_comb begin
    sel_d     = stall ? sel_q : region;
    pend_d    = strobe;
    err_d     = accept && m.enable && !mapped;
    state_d   = state_q;
    fault_evt = err_d;
    fault_src = m.addr;
    if (state_q == IDLE && pend_q && stall) state_d = WAIT;
    if (state_q == WAIT && !stall)          state_d = IDLE;
`ifdef BUS_FABRIC_TIMEOUT_EN
    if (wd_expire) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      fault_evt = 1'b1;
      fault_src = acc_addr_q;
    end
`endif
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    if (fault_clr_i) begin
      fault_valid_d = 1'b0;
      fault_addr_d  = '0;
    end
    // A fault arriving with the clear wins, so it is never lost.
    if (fault_evt && (!fault_valid_q || fault_clr_i)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = fault_src;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      pend_q        <= 1'b0;
      err_q         <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      pend_q        <= pend_d;
      err_q         <= err_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_fabric.sv
// ============================================================================
// tb_bus_fabric : vector table, directed corner sequences and random traffic
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bus_fabric;
  import bus_pkg::*;

`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 255;
`endif

  logic         clk;
  logic         rstn;
  logic [7:0]   s_enable;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_addr;
  logic [31:0]  s_wvalue;
  logic [255:0] s_rvalue;
  logic [7:0]   s_ready;
  logic         fault_clr;
  logic         fault_valid;
  logic [31:0]  fault_addr;

  int n_tests = 0;
  int n_fail  = 0;

  bus_fabric_if bus();

  bus_fabric #(
    .SEL_BITS       (3),
    .N_SLAVES       (8),
    .REGION_MASK    (8'b0001_0111),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .m             (bus),
    .s_enable_o    (s_enable),
    .s_wstrb_o     (s_wstrb),
    .s_addr_o      (s_addr),
    .s_wvalue_o    (s_wvalue),
    .s_rvalue_i    (s_rvalue),
    .s_ready_i     (s_ready),
    .fault_clr_i   (fault_clr),
    .fault_valid_o (fault_valid),
    .fault_addr_o  (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [7:0]  exp_sen;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  bit   populated [8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cafe_slaves();
    for (int i = 0; i < 8; i++) s_rvalue[32*i +: 32] = 32'hCAFE_0000 + i;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  int          r, k, stalls, exp_stall;
  bit          clr, mp, exp_err;
  logic [31:0] a, exp_data, fa;
  logic        fv;

  initial begin
    populated = '{1, 1, 1, 0, 1, 0, 0, 0};
    vecs[0] = '{32'h0000_0004, 4'b0000, 8'h01, 1'b0, 32'hCAFE_0000};
    vecs[1] = '{32'h2000_0010, 4'b0000, 8'h02, 1'b0, 32'hCAFE_0001};
    vecs[2] = '{32'h4000_0100, 4'b0011, 8'h04, 1'b0, 32'hCAFE_0002};
    vecs[3] = '{32'h6000_0000, 4'b0000, 8'h00, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h8000_0008, 4'b1111, 8'h10, 1'b0, 32'hCAFE_0004};
    vecs[5] = '{32'hA000_0000, 4'b0000, 8'h00, 1'b1, 32'h0000_0000};
    vecs[6] = '{32'hC000_0020, 4'b1000, 8'h00, 1'b1, 32'h0000_0000};
    vecs[7] = '{32'hE000_0004, 4'b0000, 8'h00, 1'b1, 32'h0000_0000};

    // Reset state; addr points at region 1 so a wrong sel_q is visible on rvalue.
    rstn       = 1'b0;
    bus.enable = 1'b0;
    bus.wstrb  = 4'b0;
    bus.addr   = 32'h2000_0000;
    bus.wvalue = 32'h0;
    s_ready    = 8'hFF;
    fault_clr  = 1'b0;
    set_cafe_slaves();
    step(); step(); step();
    #1;
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_fault_valid", 32'(fault_valid), 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_sen", 32'(s_enable), 32'h0);
    chk("rst_rvalue_sel0", bus.rvalue, 32'hCAFE_0000);
    rstn = 1'b1;
    step();

    // Zero-wait vector table across mapped and unmapped regions.
    for (int i = 0; i < 8; i++) begin
      bus.enable = 1'b1;
      bus.addr   = vecs[i].addr;
      bus.wstrb  = vecs[i].wstrb;
      bus.wvalue = 32'h1234_0000 + i;
      #1;
      chk($sformatf("tbl_sen[%0d]", i), 32'(s_enable), 32'(vecs[i].exp_sen));
      chk($sformatf("tbl_wstrb[%0d]", i), 32'(s_wstrb), 32'(vecs[i].wstrb));
      chk($sformatf("tbl_wvalue[%0d]", i), s_wvalue, 32'h1234_0000 + i);
      step();
      bus.enable = 1'b0;
      #1;
      chk($sformatf("tbl_err[%0d]", i), 32'(bus.err), 32'(vecs[i].exp_err));
      chk($sformatf("tbl_rdata[%0d]", i), bus.rvalue, vecs[i].exp_rdata);
      chk($sformatf("tbl_stall[%0d]", i), 32'(bus.stall), 32'h0);
      step();
    end
    #1;
    chk("tbl_fault_first", fault_addr, 32'h6000_0000);
    step();

    // Region 2 write with three wait cycles.
    s_ready    = 8'hFB;
    bus.enable = 1'b1;
    bus.addr   = 32'h4000_0040;
    bus.wstrb  = 4'b0011;
    #1;
    chk("ws_sen", 32'(s_enable), 32'h0000_0004);
    step();
    bus.enable = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      #1;
      chk($sformatf("ws_stall[%0d]", j), 32'(bus.stall), 32'h1);
      chk($sformatf("ws_sen_wait[%0d]", j), 32'(s_enable), 32'h0);
      step();
    end
    s_ready = 8'hFF;
    #1;
    chk("ws_stall_done", 32'(bus.stall), 32'h0);
    chk("ws_rdata", bus.rvalue, 32'hCAFE_0002);
    step();

    // Sticky fault register and clear/new-fault collision.
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    #1;
    chk("flt_clr_valid", 32'(fault_valid), 32'h0);
    chk("flt_clr_addr", fault_addr, 32'h0);
    bus.enable = 1'b1;
    bus.addr   = 32'h6000_0000;
    bus.wstrb  = 4'b0;
    #1;
    chk("flt_sen_unmapped", 32'(s_enable), 32'h0);
    step();
    bus.enable = 1'b0;
    #1;
    chk("flt1_err", 32'(bus.err), 32'h1);
    chk("flt1_rdata", bus.rvalue, 32'h0);
    chk("flt1_valid", 32'(fault_valid), 32'h1);
    chk("flt1_addr", fault_addr, 32'h6000_0000);
    step();
    #1;
    chk("flt1_err_pulse", 32'(bus.err), 32'h0);
    bus.enable = 1'b1;
    bus.addr   = 32'hE000_0004;
    step();
    bus.enable = 1'b0;
    #1;
    chk("flt2_err", 32'(bus.err), 32'h1);
    chk("flt2_addr_sticky", fault_addr, 32'h6000_0000);
    step();
    bus.enable = 1'b1;
    bus.addr   = 32'hA000_0000;
    fault_clr  = 1'b1;
    step();
    bus.enable = 1'b0;
    fault_clr  = 1'b0;
    #1;
    chk("flt3_err", 32'(bus.err), 32'h1);
    chk("flt3_valid", 32'(fault_valid), 32'h1);
    chk("flt3_addr", fault_addr, 32'hA000_0000);
    step();

    // Asynchronous reset while a region 4 access is in WAIT.
    s_ready    = 8'hEF;
    bus.enable = 1'b1;
    bus.addr   = 32'h8000_0000;
    step();
    bus.enable = 1'b0;
    step();
    #1;
    chk("rw_stall_before", 32'(bus.stall), 32'h1);
    rstn = 1'b0;
    #1;
    chk("rw_stall", 32'(bus.stall), 32'h0);
    chk("rw_err", 32'(bus.err), 32'h0);
    chk("rw_fault_valid", 32'(fault_valid), 32'h0);
    chk("rw_fault_addr", fault_addr, 32'h0);
    step();
    rstn       = 1'b1;
    s_ready    = 8'hFF;
    bus.enable = 1'b1;
    bus.addr   = 32'h0000_0008;
    step();
    bus.enable = 1'b0;
    #1;
    chk("rw_after_stall", 32'(bus.stall), 32'h0);
    chk("rw_after_rdata", bus.rvalue, 32'hCAFE_0000);
    step();

`ifdef BUS_FABRIC_TIMEOUT_EN
    // Hung region 4 slave is cut off after TB_TMO stalled cycles.
    s_ready    = 8'hEF;
    bus.enable = 1'b1;
    bus.addr   = 32'h8000_0010;
    step();
    bus.enable = 1'b0;
    for (int j = 1; j <= TB_TMO; j++) begin
      #1;
      chk($sformatf("to_stall[%0d]", j), 32'(bus.stall), 32'h1);
      step();
    end
    #1;
    chk("to_stall_end", 32'(bus.stall), 32'h0);
    chk("to_err", 32'(bus.err), 32'h1);
    chk("to_rdata", bus.rvalue, 32'h0);
    chk("to_fault_valid", 32'(fault_valid), 32'h1);
    chk("to_fault_addr", fault_addr, 32'h8000_0010);
    s_ready = 8'hFF;
    step();
    #1;
    chk("to_late_ready_err", 32'(bus.err), 32'h0);
    chk("to_late_ready_stall", 32'(bus.stall), 32'h0);
    step();
`endif

    // Random traffic against a transaction-level reference model.
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    fv = 1'b0;
    fa = 32'h0;
    for (int t = 0; t < 150; t++) begin
      r   = $urandom_range(0, 7);
      k   = $urandom_range(0, 6);
      clr = ($urandom_range(0, 3) == 0);
      a   = {r[2:0], 29'($urandom)};
      for (int i = 0; i < 8; i++) s_rvalue[32*i +: 32] = $urandom;
      mp        = populated[r];
      exp_err   = !mp || (k >= TB_TMO);
      exp_stall = !mp ? 0 : ((k < TB_TMO) ? k : TB_TMO);
      exp_data  = exp_err ? 32'h0 : s_rvalue[32*r +: 32];
      if (clr) begin
        fv = 1'b0;
        fa = 32'h0;
      end
      if (exp_err && !fv) begin
        fv = 1'b1;
        fa = a;
      end

      s_ready    = 8'hFF;
      bus.enable = 1'b1;
      bus.addr   = a;
      bus.wstrb  = 4'($urandom);
      bus.wvalue = $urandom;
      fault_clr  = clr;
      #1;
      chk("rnd_sen", 32'(s_enable), mp ? 32'(8'h01 << r) : 32'h0);
      chk("rnd_saddr", s_addr, a);
      step();
      bus.enable = 1'b0;
      fault_clr  = 1'b0;
      stalls = 0;
      for (int j = 1; j <= 400; j++) begin
        s_ready[r] = (j > k);
        #1;
        if (!bus.stall) break;
        stalls++;
        step();
      end
      chk("rnd_stalls", stalls, exp_stall);
      chk("rnd_err", 32'(bus.err), 32'(exp_err));
      chk("rnd_rdata", bus.rvalue, exp_data);
      step();
      #1;
      chk("rnd_err_pulse", 32'(bus.err), 32'h0);
      chk("rnd_fault_valid", 32'(fv), 32'(fault_valid));
      chk("rnd_fault_addr", fault_addr, fa);
    end
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
